instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Central control FSM of RISC_CPU. Sits between the instruction register (opcode, acc-zero flag) and the datapath/bus (pc, acc, ir, ram/rom).
- Steps an 8-state instruction cycle: two-byte fetch, decode, execute.
- Drives rd/wr/halt onto the system bus, plus load/increment strobes to pc, acc and ir.

Parameters:
- OPW, 3, opcode width.
- NSTATE, 8, states per instruction cycle (fixed; documented for the bench).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; low forces the reset state immediately.
- ena  in  1  run enable from the reset/clock-gen logic; 0 parks the FSM in S0.
- opcode  in  3  opcode from the instruction register; valid from S2 onward.
- zero  in  1  accumulator == 0 flag.
- rd  out  1  bus read strobe.
- wr  out  1  bus write strobe.
- halt  out  1  HLT executed; sticky until reset.
- load_ir  out  1  ir captures data (high byte in S0, low byte in S1).
- inc_pc  out  1  pc += 1.
- load_pc  out  1  pc <= ir_addr (JMP).
- load_acc  out  1  acc <= ALU result.
- datactl_ena  out  1  acc drives the data bus (STO).
- fetch  out  1  high during S0–S3 (fetch half of the cycle).
- state  out  3  current state, for debug and the bench.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S0 and the halted flag is cleared.
  - All outputs are 0 except fetch=1.
  - If reset goes low mid-instruction, the instruction is aborted with no wr pulse; after release the FSM restarts at S0.
- ena=0: state is held at S0 and all strobes are 0. ena is sampled on posedge.
- Outputs are registered: each is a function of the next state and opcode, so it is asserted exactly in the cycles where state==Sx.
- Without halt, the FSM advances S0→S1→…→S7→S0, one state per clk.
- Per state:
  - S0: rd, load_ir, inc_pc (fetch high byte).
  - S1: rd, load_ir, inc_pc (fetch low byte).
  - S2: no strobes.
  - S3: HLT → halt=1 and the FSM enters HALTED; otherwise no strobes.
  - S4: ADD/AND/XOR/LDA → rd. STO → datactl_ena. JMP → load_pc. SKZ with zero=1 → inc_pc.
  - S5: ADD/AND/XOR/LDA → rd, load_acc. STO → wr, datactl_ena. JMP → load_pc, inc_pc=0.
  - S6: ADD/AND/XOR/LDA → rd. STO → datactl_ena.
  - S7: SKZ with zero=1 → inc_pc.
- SKZ skip: zero is sampled once in S4 and held internally, so the pc advances by exactly 2 (one instruction). A zero change during S4–S7 is ignored.
- HALTED:
  - Encoded as a state distinct from S0–S7; state output reads 3'd3.
  - halt=1 and all other strobes are 0. Only reset exits.
  - ena is ignored while halted.
- Mutual exclusion: rd and wr are never both 1. wr is high only in S5 and only for STO. The bench asserts both.
- Unknown opcode (X): treated as a NOP through S4–S7.

Optional Feature:
- Macro SEQ_MEM_WAIT_EN.
  - Defined: adds input mem_ready (1 bit). In S0, S1 and S5, when the state issues rd or wr, the FSM holds while mem_ready=0. The strobes stay asserted and inc_pc/load_* pulse only in the cycle mem_ready=1.
  - Undefined: the port is absent and every state lasts exactly one clk (8 clks per instruction).

Decomposition:
- Shared include cpu_defs.vh:
  - Opcode constants HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - State encodings S0..S7 and HALTED.
  - The ALU-class predicate.
- One sub-module, op_class_decode (combinational): opcode → is_alu, is_sto, is_jmp, is_skz, is_hlt.

Test Plan:
- Reset low at t=30ns, release after 150ns, ena=1 → state S0; rd and load_ir pulse in S0 and S1; inc_pc=2 pulses per instruction; fetch=1 for 4 clks then 0 for 4.
- opcode=STO → exactly one wr pulse, in S5; datactl_ena high S4–S6; rd=0 during S4–S7.
- opcode=SKZ:
  - zero=1 → 4 inc_pc pulses total per cycle (S0, S1, S4, S7).
  - zero=0 → 2 pulses.
  - zero toggled in S5 → no effect.
- opcode=JMP → load_pc high in S4 and S5, no inc_pc after S1; opcode=ADD → load_acc high in S5 only.
- opcode=HLT → halt rises in S3 and stays 1 for 20 clks with no other strobes; reset low → halt=0 asynchronously.
- SEQ_MEM_WAIT_EN with mem_ready=0 for 3 clks in S5 of STO → wr held 4 clks, state stays S5, single completion.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared opcode, state and bundle types for the RISC_CPU instruction sequencer.
// Optional feature macro: SEQ_MEM_WAIT_EN (memory wait states on bus cycles).
package instr_sequencer_pkg;

  localparam int OPW    = 3;
  localparam int NSTATE = 8;

  typedef enum logic [OPW-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  // Low three bits are what the state port shows: IDLE reads 0, HALT reads 3.
  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    S_IDLE = 4'd8,
    S_HALT = 4'd11
  } state_e;

  typedef struct packed {
    logic is_alu;
    logic is_sto;
    logic is_jmp;
    logic is_skz;
    logic is_hlt;
  } op_class_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic halt;
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic datactl_ena;
    logic fetch;
  } seq_out_t;

  localparam seq_out_t OUT_RST = '{fetch: 1'b1, default: 1'b0};

  function automatic logic is_alu_op(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/instr_sequencer_op_class_decode.sv
// Opcode classifier for the sequencer; unknown codes fall out as a NOP.
module op_class_decode
  import instr_sequencer_pkg::*;
(
  input  logic [OPW-1:0] opcode_i,
  output op_class_t      cls_o
);

  always_comb begin
    cls_o        = '0;
    cls_o.is_alu = is_alu_op(opcode_i);
    case (opcode_i)
      OP_HLT:  cls_o.is_hlt = 1'b1;
      OP_SKZ:  cls_o.is_skz = 1'b1;
      OP_STO:  cls_o.is_sto = 1'b1;
      OP_JMP:  cls_o.is_jmp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// RISC_CPU control FSM: two-byte fetch, decode, execute over S0..S7.
// Define SEQ_MEM_WAIT_EN to add mem_ready wait states in S0, S1 and S5.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           ena,
`ifdef SEQ_MEM_WAIT_EN
  input  logic           mem_ready,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           rd,
  output logic           wr,
  output logic           halt,
  output logic           load_ir,
  output logic           inc_pc,
  output logic           load_pc,
  output logic           load_acc,
  output logic           datactl_ena,
  output logic           fetch,
  output logic [2:0]     state
);

  state_e    state_q, state_d;
  seq_out_t  out_q, out_d;
  logic      zero_q, zero_d;
  op_class_t cls;
  logic      stall;

  op_class_decode u_dec (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

`ifdef SEQ_MEM_WAIT_EN
  logic wait_q, wait_d;

  assign stall  = wait_q & ~mem_ready;
  assign wait_d = (state_d inside {S0, S1, S5}) &
                  (out_d.rd | out_d.wr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      zero_q  <= 1'b0;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (!ena) begin
      state_d = S_IDLE;
    end else if (!stall) begin
      unique case (state_q)
        S_IDLE:  state_d = S0;
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = cls.is_hlt ? S_HALT : S3;
        S3:      state_d = S4;
        S4:      state_d = S5;
        S5:      state_d = S6;
        S6:      state_d = S7;
        S7:      state_d = S0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    out_d  = '0;
    zero_d = zero_q;
    if (state_d == S4 && state_q != S4) zero_d = zero;
    out_d.fetch = state_d inside {S_IDLE, S0, S1, S2, S3};
    unique case (state_d)
      S0, S1: begin
        out_d.rd      = 1'b1;
        out_d.load_ir = 1'b1;
        out_d.inc_pc  = 1'b1;
      end
      S4: begin
        out_d.rd          = cls.is_alu;
        out_d.datactl_ena = cls.is_sto;
        out_d.load_pc     = cls.is_jmp;
        out_d.inc_pc      = cls.is_skz & zero_d;
      end
      S5: begin
        out_d.rd          = cls.is_alu;
        out_d.load_acc    = cls.is_alu;
        out_d.wr          = cls.is_sto;
        out_d.datactl_ena = cls.is_sto;
        out_d.load_pc     = cls.is_jmp;
      end
      S6: begin
        out_d.rd          = cls.is_alu;
        out_d.datactl_ena = cls.is_sto;
      end
      S7:      out_d.inc_pc = cls.is_skz & zero_d;
      S_HALT:  out_d.halt   = 1'b1;
      default: ;
    endcase
  end

  assign rd          = out_q.rd;
  assign wr          = out_q.wr;
  assign halt        = out_q.halt;
  assign datactl_ena = out_q.datactl_ena;
  assign fetch       = out_q.fetch;
  assign load_ir     = out_q.load_ir & ~stall;
  assign inc_pc      = out_q.inc_pc & ~stall;
  assign load_pc     = out_q.load_pc & ~stall;
  assign load_acc    = out_q.load_acc & ~stall;

  always_comb begin
    if (state_q == S_HALT)      state = 3'd3;
    else if (state_q == S_IDLE) state = 3'd0;
    else                        state = state_q[2:0];
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: fetch, per-opcode strobes, SKZ, HLT, reset.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       rd, wr, halt, load_ir, inc_pc, load_pc, load_acc;
  logic       datactl_ena, fetch;
  logic [2:0] state;
`ifdef SEQ_MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] r_rd, r_wr, r_inc, r_ldpc, r_ldacc, r_dctl, r_ldir, r_fetch;
  logic [2:0] r_st [8];

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
`ifdef SEQ_MEM_WAIT_EN
    .mem_ready   (mem_ready),
`endif
    .opcode      (opcode),
    .zero        (zero),
    .rd          (rd),
    .wr          (wr),
    .halt        (halt),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .datactl_ena (datactl_ena),
    .fetch       (fetch),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (rd && wr) begin
        errors++;
        $display("FAIL rd_wr_excl rd=%0b wr=%0b required not both", rd, wr);
      end
      checks++;
      if (wr && (state != 3'd5 || opcode != OP_STO)) begin
        errors++;
        $display("FAIL wr_only_s5_sto state=%0d op=%0d", state, opcode);
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_sync state=%0d required %0d", tag, state, s);
    end
  endtask

  // Runs one instruction S0..S7, recording each cycle at the negedge.
  task automatic capture(input logic [2:0] op, input logic z,
                         input int flip_at);
    wait_state(3'd7, "capture");
    opcode = op;
    zero   = z;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      r_rd[k]    = rd;
      r_wr[k]    = wr;
      r_inc[k]   = inc_pc;
      r_ldpc[k]  = load_pc;
      r_ldacc[k] = load_acc;
      r_dctl[k]  = datactl_ena;
      r_ldir[k]  = load_ir;
      r_fetch[k] = fetch;
      r_st[k]    = state;
      if (k == flip_at) zero = ~zero;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    ena    = 1'b0;
    opcode = OP_LDA;
    zero   = 1'b0;
    #30 reset = 1'b0;
    #1;
    checks++;
    if ({rd, wr, halt, load_ir, inc_pc, load_pc, load_acc, datactl_ena}
        !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got=%b required 00000000",
               {rd, wr, halt, load_ir, inc_pc, load_pc, load_acc,
                datactl_ena});
    end
    checks++;
    if (fetch !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state fetch=%b state=%0d required 1/0",
               fetch, state);
    end
    #149 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || rd !== 1'b0 || inc_pc !== 1'b0) begin
      errors++;
      $display("FAIL ena_low_park state=%0d rd=%b inc=%b required 0/0/0",
               state, rd, inc_pc);
    end
    ena = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || rd !== 1'b1 || load_ir !== 1'b1) begin
      errors++;
      $display("FAIL first_s0 state=%0d rd=%b ldir=%b required 0/1/1",
               state, rd, load_ir);
    end
  endtask

  task automatic test_fetch_add();
    capture(OP_ADD, 1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (r_st[k] !== 3'(k)) begin
        errors++;
        $display("FAIL state_seq[%0d] got=%0d required %0d", k, r_st[k], k);
      end
    end
    checks++;
    if (r_fetch !== 8'b0000_1111) begin
      errors++;
      $display("FAIL fetch got=%b required 00001111", r_fetch);
    end
    checks++;
    if (r_ldir !== 8'b0000_0011 || r_inc !== 8'b0000_0011) begin
      errors++;
      $display("FAIL add_ldir_inc got=%b/%b required 00000011", r_ldir, r_inc);
    end
    checks++;
    if (r_rd !== 8'b0111_0011) begin
      errors++;
      $display("FAIL add_rd got=%b required 01110011", r_rd);
    end
    checks++;
    if (r_ldacc !== 8'b0010_0000 || r_wr !== 8'h00 || r_ldpc !== 8'h00) begin
      errors++;
      $display("FAIL add_ldacc got=%b wr=%b ldpc=%b required 00100000/0/0",
               r_ldacc, r_wr, r_ldpc);
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0] ops [3];
    ops[0] = OP_AND;
    ops[1] = OP_XOR;
    ops[2] = OP_LDA;
    for (int i = 0; i < 3; i++) begin
      capture(ops[i], 1'b1, -1);
      checks++;
      if (r_rd !== 8'b0111_0011 || r_ldacc !== 8'b0010_0000) begin
        errors++;
        $display("FAIL alu_op%0d rd=%b ldacc=%b required 01110011/00100000",
                 ops[i], r_rd, r_ldacc);
      end
    end
  endtask

  task automatic test_sto();
    capture(OP_STO, 1'b0, -1);
    checks++;
    if (r_wr !== 8'b0010_0000) begin
      errors++;
      $display("FAIL sto_wr got=%b required 00100000", r_wr);
    end
    checks++;
    if (r_dctl !== 8'b0111_0000) begin
      errors++;
      $display("FAIL sto_dctl got=%b required 01110000", r_dctl);
    end
    checks++;
    if (r_rd !== 8'b0000_0011 || r_ldacc !== 8'h00) begin
      errors++;
      $display("FAIL sto_rd got=%b ldacc=%b required 00000011/0",
               r_rd, r_ldacc);
    end
  endtask

  task automatic test_skz();
    capture(OP_SKZ, 1'b1, -1);
    checks++;
    if (r_inc !== 8'b1001_0011 || $countones(r_inc) != 4) begin
      errors++;
      $display("FAIL skz_z1 inc=%b required 10010011", r_inc);
    end
    capture(OP_SKZ, 1'b0, -1);
    checks++;
    if (r_inc !== 8'b0000_0011) begin
      errors++;
      $display("FAIL skz_z0 inc=%b required 00000011", r_inc);
    end
    capture(OP_SKZ, 1'b1, 5);
    checks++;
    if (r_inc !== 8'b1001_0011) begin
      errors++;
      $display("FAIL skz_flip_1to0 inc=%b required 10010011", r_inc);
    end
    capture(OP_SKZ, 1'b0, 5);
    checks++;
    if (r_inc !== 8'b0000_0011) begin
      errors++;
      $display("FAIL skz_flip_0to1 inc=%b required 00000011", r_inc);
    end
  endtask

  task automatic test_jmp();
    capture(OP_JMP, 1'b1, -1);
    checks++;
    if (r_ldpc !== 8'b0011_0000) begin
      errors++;
      $display("FAIL jmp_ldpc got=%b required 00110000", r_ldpc);
    end
    checks++;
    if (r_inc !== 8'b0000_0011 || r_rd !== 8'b0000_0011) begin
      errors++;
      $display("FAIL jmp_inc_rd inc=%b rd=%b required 00000011",
               r_inc, r_rd);
    end
  endtask

  task automatic test_ena_park();
    wait_state(3'd2, "ena");
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd0 || {rd, wr, load_ir, inc_pc, load_pc, load_acc,
                             datactl_ena} !== 7'h00) begin
        errors++;
        $display("FAIL ena_park[%0d] state=%0d rd=%b inc=%b required 0/0/0",
                 i, state, rd, inc_pc);
      end
    end
    ena = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || rd !== 1'b1 || inc_pc !== 1'b1) begin
      errors++;
      $display("FAIL ena_resume state=%0d rd=%b inc=%b required 0/1/1",
               state, rd, inc_pc);
    end
  endtask

  task automatic test_reset_abort();
    wait_state(3'd7, "abort");
    opcode = OP_STO;
    wait_state(3'd4, "abort_s4");
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || wr !== 1'b0 || datactl_ena !== 1'b0 ||
        fetch !== 1'b1) begin
      errors++;
      $display("FAIL abort_async state=%0d wr=%b dctl=%b fetch=%b req 0/0/0/1",
               state, wr, datactl_ena, fetch);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || rd !== 1'b1 || wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart state=%0d rd=%b wr=%b required 0/1/0",
               state, rd, wr);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL abort_s1 state=%0d required 1", state);
    end
  endtask

  task automatic test_hlt();
    wait_state(3'd7, "hlt");
    opcode = OP_HLT;
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 3'd3 || halt !== 1'b1) begin
      errors++;
      $display("FAIL hlt_rise state=%0d halt=%b required 3/1", state, halt);
    end
    for (int i = 0; i < 20; i++) begin
      if (i == 5)  ena = 1'b0;
      if (i == 10) ena = 1'b1;
      @(negedge clk);
      checks++;
      if (halt !== 1'b1 || state !== 3'd3 ||
          {rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena}
          !== 7'h00) begin
        errors++;
        $display("FAIL hlt_hold[%0d] halt=%b state=%0d rd=%b inc=%b req 1/3",
                 i, halt, state, rd, inc_pc);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (halt !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL hlt_reset halt=%b state=%0d required 0/0", halt, state);
    end
    opcode = OP_LDA;
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef SEQ_MEM_WAIT_EN
  task automatic test_mem_wait();
    wait_state(3'd7, "mem");
    opcode = OP_STO;
    wait_state(3'd4, "mem_s4");
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 3'd5 || wr !== 1'b1 || datactl_ena !== 1'b1) begin
        errors++;
        $display("FAIL mem_hold[%0d] state=%0d wr=%b required 5/1",
                 i, state, wr);
      end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd6 || wr !== 1'b0) begin
      errors++;
      $display("FAIL mem_done state=%0d wr=%b required 6/0", state, wr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_add();
    test_alu_ops();
    test_sto();
    test_skz();
    test_jmp();
    test_ena_park();
    test_reset_abort();
`ifdef SEQ_MEM_WAIT_EN
    test_mem_wait();
`endif
    test_hlt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
